seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing controller that shares one BCD-to-7-segment decoder across NUM_DIGITS common-anode/cathode digit positions. Accepts a full display word through a valid/ready handshake and holds it in a pending buffer. Commits the pending word at frame boundaries so a frame never shows a mix of old and new digits. Scans digits with a programmable dwell and dead-time gap, blanks leading zeros and invalid codes, and drives the decoder's BCD input plus the one-hot digit enables.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
DWELL_CYCLES, 1000, clk cycles each digit is lit (>=2)
GAP_CYCLES, 2, clk cycles all digits are off between digits (anti-ghosting, >=1)
BLANK_LEADING, 1, 1 = suppress leading zeros (digit 0 is never suppressed)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display off
load_valid  input  1  load_bcd/load_dp valid
load_ready  output  1  pending buffer empty; can accept a word
load_bcd  input  4*NUM_DIGITS  digit i at bits [4i+3:4i]; digit 0 = least significant
load_dp  input  NUM_DIGITS  decimal point per digit
bcd_out  output  4  BCD code to the shared decoder (A=bit3 .. D=bit0)
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable; all-zero when off or in gap
dp_out  output  1  decimal point for the selected digit
blank_out  output  1  1 = decoder segments must be forced off
frame_done  output  1  one-cycle pulse after the last digit's dwell

Behaviour:
- Reset (async, rst_n=0): state OFF; digit_sel=0; bcd_out=0; dp_out=0; blank_out=1; frame_done=0; load_ready=1; display and pending registers cleared to 0 (pending marked empty).
- Handshake: a transfer occurs when load_valid && load_ready at a clk edge. The word is captured into pending, and load_ready falls the next cycle. load_ready must not depend combinationally on load_valid.
- Commit: pending is copied to the display register and load_ready rises when either condition holds:
  - in OFF, the cycle after capture;
  - while scanning, on the cycle frame_done is asserted.
  - A capture and a commit in the same cycle are impossible, because load_ready=0 whenever pending is full.
- States:
  - OFF: outputs as in reset.
  - SHOW: digit_sel = one-hot(idx); outputs registered from the display register.
  - GAP: digit_sel=0; blank_out=1.
- Transitions:
  - OFF->SHOW when enable=1, with idx=0 and the dwell counter loaded to DWELL_CYCLES-1.
  - SHOW->GAP when the counter reaches 0; counter reloaded to GAP_CYCLES-1.
  - GAP->SHOW when the counter reaches 0; idx increments and wraps NUM_DIGITS-1 -> 0.
  - frame_done pulses on the SHOW->GAP transition when idx=NUM_DIGITS-1.
- enable falling: go to OFF on the next edge from any state. idx and counter are reset; pending is kept.
- Latency: first digit lit 1 cycle after enable is sampled high. Each digit is lit exactly DWELL_CYCLES cycles. Frame period is NUM_DIGITS*(DWELL_CYCLES+GAP_CYCLES).
- Leading-zero blanking (BLANK_LEADING=1): digit i (i>0) is blanked when digits NUM_DIGITS-1..i are all 0.
- When a digit is blanked by leading-zero suppression or holds an invalid code (>9):
  - digit_sel is still asserted;
  - blank_out=1;
  - bcd_out carries the raw value;
  - dp_out still follows load_dp.
- Counter widths are $clog2 of the parameter values; no overflow is possible.

Decomposition:
- Shared package seg_scan_pkg: state enum {OFF, SHOW, GAP}; BCD_MAX=9; helper function for the one-hot decode.
- Sub-module scan_timer: loadable down-counter with a zero flag, used for both dwell and gap.
- The leading-zero logic stays inline.

Test Plan:
- Reset mid-SHOW (rst_n low for 3 cycles) -> digit_sel=0, blank_out=1, load_ready=1 within the same cycle, asynchronously.
- NUM_DIGITS=4, DWELL=4, GAP=2:
  - load 0x1234, enable=1 -> digit_sel sequence 0001,0000,0010,0000,0100,0000,1000;
  - bcd_out follows 4,3,2,1;
  - each digit lit 4 cycles, gaps 2 cycles;
  - frame_done pulses once every 24 cycles.
- Load 0x0007 with BLANK_LEADING=1 -> blank_out=1 on digits 3,2,1 and blank_out=0 on digit 0. Load 0x0000 -> only digit 0 unblanked, showing 0.
- While scanning 0x1234:
  - load 0x5678 mid-frame -> load_ready=0 until frame_done;
  - the remainder of the frame still shows 1234;
  - the next frame shows 5678;
  - a second load_valid held during that time is not accepted until load_ready=1.
- Load 0x1A34 -> digit 2 shows bcd_out=0xA with blank_out=1, and the other digits are unaffected.
- Drop enable during GAP -> OFF next cycle. Re-enable -> scan restarts at digit 0 with a full dwell.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned MAX_DIGITS = 8;

  // One-hot decode of a digit index; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_timer.sv
// Loadable down-counter with a registered zero flag; shared by dwell and gap phases.
module scan_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = value_i;
      zero_d = (value_i == '0);
    end else if (!zero_q) begin
      cnt_d  = cnt_q - WIDTH'(1);
      zero_d = (cnt_q == WIDTH'(1));
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned word commit.
module seven_seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DWELL_CYCLES  = 1000,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    dp_out,
  output logic                    blank_out,
  output logic                    frame_done
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_value;
  logic                  tmr_zero;

  logic [BCD_W-1:0]      pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [BCD_W-1:0]      disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  ready_q, ready_d;
  logic                  capture, commit;

  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;
  logic [3:0]            sel_bcd;

  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;

  // Dwell / gap sequencing counter.
  scan_timer #(.WIDTH(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  // Scan FSM next-state, digit index and timer control.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    frame_done_d = 1'b0;
    case (state_q)
      OFF: begin
        tmr_load = 1'b1;
        idx_d    = '0;
        if (enable) begin
          state_d   = SHOW;
          tmr_value = DWELL_LOAD;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_d  = OFF;
          idx_d    = '0;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d      = GAP;
          tmr_load     = 1'b1;
          tmr_value    = GAP_LOAD;
          frame_done_d = (idx_q == LAST_IDX);
        end
      end
      GAP: begin
        if (!enable) begin
          state_d  = OFF;
          idx_d    = '0;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d   = SHOW;
          tmr_load  = 1'b1;
          tmr_value = DWELL_LOAD;
          idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Pending-word handshake and frame-aligned commit into the display register.
  always_comb begin
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    ready_d    = ready_q;
    capture    = load_valid && ready_q;
    commit     = !ready_q && ((state_q == OFF) || frame_done_d);
    if (commit) begin
      disp_bcd_d = pend_bcd_q;
      disp_dp_d  = pend_dp_q;
      ready_d    = 1'b1;
    end
    if (capture) begin
      pend_bcd_d = load_bcd;
      pend_dp_d  = load_dp;
      ready_d    = 1'b0;
    end
  end

  // Leading-zero flags: digit i is suppressed when it and every higher digit are zero.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_bcd_d[4*i +: 4] == 4'd0);
      lz[i]    = zero_run && (BLANK_LEADING != 0);
    end
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    digit_sel_d = '0;
    bcd_d       = '0;
    dp_d        = 1'b0;
    blank_d     = 1'b1;
    sel_bcd     = disp_bcd_d[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW) begin
      digit_sel_d = NUM_DIGITS'(onehot_sel(3'(idx_d)));
      bcd_d       = sel_bcd;
      dp_d        = disp_dp_d[idx_d];
      blank_d     = lz[idx_d] || (sel_bcd > BCD_MAX);
    end
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      idx_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      ready_q      <= 1'b1;
      digit_sel_q  <= '0;
      bcd_q        <= '0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      ready_q      <= ready_d;
      digit_sel_q  <= digit_sel_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ready_q;
  assign digit_sel  = digit_sel_q;
  assign bcd_out    = bcd_q;
  assign dp_out     = dp_q;
  assign blank_out  = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position arithmetic reference model, randomized loads.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned GP    = 2;
  localparam int unsigned SLOT  = DW + GP;
  localparam int unsigned FRAME = N * SLOT;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           load_valid;
  logic           load_ready;
  logic [4*N-1:0] load_bcd;
  logic [N-1:0]   load_dp;
  logic [3:0]     bcd_out;
  logic [N-1:0]   digit_sel;
  logic           dp_out;
  logic           blank_out;
  logic           frame_done;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  bit             m_on;
  int unsigned    m_t;
  logic [4*N-1:0] m_pend_bcd, m_disp_bcd;
  logic [N-1:0]   m_pend_dp, m_disp_dp;
  bit             m_pend_full;

  // Expected outputs for the current cycle
  logic [N-1:0] e_sel;
  logic [3:0]   e_bcd;
  logic         e_dp, e_blank, e_fd, e_rdy;
  bit           e_vis;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS    (N),
    .DWELL_CYCLES  (DW),
    .GAP_CYCLES    (GP),
    .BLANK_LEADING (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bcd   (load_bcd),
    .load_dp    (load_dp),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .dp_out     (dp_out),
    .blank_out  (blank_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display outputs from scan time: position in frame selects digit and lit/gap.
  task automatic model_outputs();
    int unsigned p, k;
    logic [3:0]  digit;
    e_sel   = '0;
    e_bcd   = '0;
    e_dp    = 1'b0;
    e_blank = 1'b1;
    e_vis   = 1'b1;
    if (m_on) begin
      p     = m_t % FRAME;
      k     = p / SLOT;
      e_vis = 1'b0;
      if ((p % SLOT) < DW) begin
        e_vis   = 1'b1;
        digit   = 4'(m_disp_bcd >> (4 * k));
        e_sel   = N'(1 << k);
        e_bcd   = digit;
        e_dp    = m_disp_dp[k];
        e_blank = ((k > 0) && ((m_disp_bcd >> (4 * k)) == '0)) || (digit > 4'd9);
      end
    end
  endtask

  task automatic model_reset();
    m_on        = 1'b0;
    m_t         = 0;
    m_pend_bcd  = '0;
    m_pend_dp   = '0;
    m_disp_bcd  = '0;
    m_disp_dp   = '0;
    m_pend_full = 1'b0;
    e_fd        = 1'b0;
    e_rdy       = 1'b1;
    model_outputs();
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit cap, was_on, fd, cm;
    cap    = load_valid && !m_pend_full;
    was_on = m_on;
    if (!enable) begin
      m_on = 1'b0;
      m_t  = 0;
    end else if (!m_on) begin
      m_on = 1'b1;
      m_t  = 0;
    end else begin
      m_t++;
    end
    fd = was_on && m_on && ((m_t % FRAME) == FRAME - GP);
    cm = m_pend_full && (!was_on || fd);
    if (cm) begin
      m_disp_bcd  = m_pend_bcd;
      m_disp_dp   = m_pend_dp;
      m_pend_full = 1'b0;
    end
    if (cap) begin
      m_pend_bcd  = load_bcd;
      m_pend_dp   = load_dp;
      m_pend_full = 1'b1;
    end
    e_fd  = fd;
    e_rdy = !m_pend_full;
    model_outputs();
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [N+7:0] act_vec();
    return {digit_sel, e_vis ? bcd_out : 4'h0, e_vis ? dp_out : 1'b0, blank_out, frame_done, load_ready};
  endfunction

  function automatic logic [N+7:0] exp_vec();
    return {e_sel, e_bcd, e_dp, e_blank, e_fd, e_rdy};
  endfunction

  function automatic logic [4*N-1:0] rand_word();
    logic [4*N-1:0] w;
    for (int i = 0; i < int'(N); i++)
      w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return w;
  endfunction

  // Go idle, then hand a word over while OFF so it commits immediately.
  task automatic load_off(input logic [4*N-1:0] w, input logic [N-1:0] d);
    enable     = 1'b0;
    load_valid = 1'b0;
    tick();
    tick();
    load_bcd   = w;
    load_dp    = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_bcd   = '0;
    load_dp    = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_scan_1234();
    logic [3:0] seq[$];
    logic [3:0] exp_seq[7];
    int         fd_cnt;
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
    fd_cnt  = 0;
    load_off(16'h1234, 4'b0100);
    enable = 1'b1;
    for (int c = 0; c < 2 * int'(FRAME); c++) begin
      tick();
      if (c < int'(FRAME) - int'(GP)) begin
        if (seq.size() == 0 || seq[$] != digit_sel) seq.push_back(digit_sel);
      end
      if (frame_done === 1'b1) fd_cnt++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL scan_1234 cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (seq.size() != 7) begin
      errors++;
      $display("FAIL sel_seq_len got=%0d exp=7", seq.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (seq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL sel_seq[%0d] got=%b exp=%b", i, seq[i], exp_seq[i]);
        end
      end
    end
    vectors++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL frame_done_count got=%0d exp=2", fd_cnt);
    end
  endtask

  task automatic test_leading_zero();
    logic [4*N-1:0] words[2];
    words = '{16'h0007, 16'h0000};
    foreach (words[w]) begin
      load_off(words[w], 4'b0000);
      enable = 1'b1;
      for (int c = 0; c < int'(FRAME); c++) begin
        tick();
        vectors++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL leading_zero w=%h cyc=%0d got=%h exp=%h", words[w], c, act_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    load_off(16'h1234, 4'b0000);
    enable = 1'b1;
    for (int c = 0; c < 3 * int'(FRAME); c++) begin
      load_valid = (c >= 7) && (c < 70);
      load_bcd   = (c == 7) ? 16'h5678 : 16'h4321;
      load_dp    = (c == 7) ? 4'b0001 : 4'b1000;
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midframe_load cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_invalid_code();
    load_off(16'h1A34, 4'b1111);
    enable = 1'b1;
    for (int c = 0; c < int'(FRAME); c++) begin
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL invalid_code cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_enable_drop();
    load_off(16'h9042, 4'b0010);
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      enable = !(c >= int'(DW) + 1 && c < int'(DW) + 4);
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_show();
    load_off(16'h1234, 4'b0000);
    enable = 1'b1;
    tick();
    load_bcd   = 16'h8888;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", act_vec(), exp_vec());
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) enable = !enable;
      load_valid = ($urandom_range(0, 7) == 0);
      load_bcd   = rand_word();
      load_dp    = N'($urandom);
      tick();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_leading_zero();
    test_midframe_load();
    test_invalid_code();
    test_enable_drop();
    test_reset_mid_show();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
